// File: rtl/spi_bus_arb.sv
// Round-robin arbiter that shares one spi_mnrch master between two requesters,
// with one-deep command buffering per requester and a lock for back-to-back transactions.
module spi_bus_arb #(
  parameter int DW       = 16,
  parameter int HOLD_MAX = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_wrt,
  input  logic          req0_lock,
  input  logic [DW-1:0] req0_wt_data,
  output logic          req0_done,
  output logic [DW-1:0] req0_rd_data,
  input  logic          req1_wrt,
  input  logic          req1_lock,
  input  logic [DW-1:0] req1_wt_data,
  output logic          req1_done,
  output logic [DW-1:0] req1_rd_data,
  output logic          spi_wrt,
  output logic [DW-1:0] spi_wt_data,
  input  logic          spi_done,
  input  logic [DW-1:0] spi_rd_data,
  output logic          bus_sel,
  output logic          ovf
);

  localparam int CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, HOLD} state_t;

  state_t        state, state_nxt;
  logic [1:0]    pend;
  logic [DW-1:0] data0, data1;
  logic          last_owner;
  logic          done_q;
  logic [CW-1:0] hold_cnt;

  logic done_evt, owner_lock, pick;
  logic acc0, acc1, drop0, drop1;
  logic launch_go, launch_sel, hold_clr, hold_inc;

  always_comb begin
    done_evt   = (state == BUSY) && spi_done && !done_q;
    owner_lock = bus_sel ? req1_lock : req0_lock;
    // On a tie the requester that did not own the bus last goes first.
    pick       = (pend == 2'b11) ? ~last_owner : pend[1];
    acc0       = req0_wrt && !pend[0] && !((state == BUSY) && !bus_sel);
    acc1       = req1_wrt && !pend[1] && !((state == BUSY) && bus_sel);
    drop0      = req0_wrt && !acc0;
    drop1      = req1_wrt && !acc1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    launch_go  = 1'b0;
    launch_sel = bus_sel;
    hold_clr   = 1'b0;
    hold_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (|pend) begin
          launch_go  = 1'b1;
          launch_sel = pick;
          state_nxt  = LAUNCH;
        end
      end
      LAUNCH: state_nxt = BUSY;
      BUSY: begin
        if (done_evt) begin
          if (owner_lock) begin
            state_nxt = HOLD;
            hold_clr  = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      HOLD: begin
        if (pend[bus_sel]) begin
          launch_go = 1'b1;
          state_nxt = LAUNCH;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nxt = IDLE;
        end else begin
          hold_inc = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Launch strobe and word are registered on the way into LAUNCH so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend         <= '0;
      data0        <= '0;
      data1        <= '0;
      spi_wrt      <= 1'b0;
      spi_wt_data  <= '0;
      bus_sel      <= 1'b0;
      last_owner   <= 1'b1;
      done_q       <= 1'b0;
      hold_cnt     <= '0;
      req0_done    <= 1'b0;
      req1_done    <= 1'b0;
      req0_rd_data <= '0;
      req1_rd_data <= '0;
      ovf          <= 1'b0;
    end else begin
      done_q <= spi_done;
      ovf    <= drop0 | drop1;

      pend[0] <= (pend[0] && !((state == LAUNCH) && !bus_sel)) || acc0;
      pend[1] <= (pend[1] && !((state == LAUNCH) && bus_sel)) || acc1;
      if (acc0) data0 <= req0_wt_data;
      if (acc1) data1 <= req1_wt_data;

      spi_wrt <= launch_go;
      if (launch_go) begin
        spi_wt_data <= launch_sel ? data1 : data0;
        bus_sel     <= launch_sel;
      end

      req0_done <= done_evt && !bus_sel;
      req1_done <= done_evt && bus_sel;
      if (done_evt) begin
        last_owner <= bus_sel;
        if (bus_sel) req1_rd_data <= spi_rd_data;
        else         req0_rd_data <= spi_rd_data;
      end

      if (hold_clr)      hold_cnt <= '0;
      else if (hold_inc) hold_cnt <= hold_cnt + 1'b1;
    end
  end

endmodule
